// File: rtl/jericalla_sequencer.sv
// Program sequencer for the jericalla datapath: fetches instructions from a synchronous ROM,
// forwards datapath ops for one cycle, and resolves BZ/HALT locally.
module jericalla_sequencer #(
    parameter int PC_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [16:0]         imem_data_i,
    output logic [16:0]         instruction_o,
    output logic                instr_valid_o,
    input  logic [31:0]         result_i,
    input  logic                z_flag_i,
    output logic [31:0]         last_result_o,
    output logic                z_q_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [2:0]          OP_HALT = 3'b111;
    localparam logic [2:0]          OP_BZ   = 3'b110;
    localparam logic [PC_WIDTH-1:0] PC_LAST = '1;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         last_result_q, last_result_d;
    logic                z_q_q, z_q_d;
    logic                err_q, err_d;

    logic [2:0]          opcode;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                at_last;

    assign opcode  = imem_data_i[16:14];
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign at_last = (pc_q == PC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            last_result_q <= '0;
            z_q_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            last_result_q <= last_result_d;
            z_q_q         <= z_q_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        last_result_d = last_result_q;
        z_q_d         = z_q_q;
        err_d         = err_q;
        imem_addr_o   = '0;
        instruction_o = '0;
        instr_valid_o = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d       = S_FETCH;
                    pc_d          = '0;
                    err_d         = 1'b0;
                    last_result_d = '0;
                    z_q_d         = 1'b0;
                end
            end
            S_FETCH: begin
                busy_o      = 1'b1;
                imem_addr_o = pc_q;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                busy_o = 1'b1;
                if (opcode == OP_HALT) begin
                    state_d = S_DONE;
                end else if (opcode == OP_BZ && z_q_q) begin
                    // A taken branch never runs off the end, even from the last address.
                    pc_d    = imem_data_i[PC_WIDTH-1:0];
                    state_d = S_FETCH;
                end else begin
                    if (opcode != OP_BZ) begin
                        instruction_o = imem_data_i;
                        instr_valid_o = 1'b1;
                        last_result_d = result_i;
                        z_q_d         = z_flag_i;
                    end
                    pc_d    = pc_inc;
                    state_d = at_last ? S_DONE : S_FETCH;
                    err_d   = err_q | at_last;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last_result_o = last_result_q;
    assign z_q_o         = z_q_q;
    assign pc_o          = pc_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed bench for jericalla_sequencer with a synchronous ROM model and a
// combinational stand-in for the jericalla datapath.
module tb_jericalla_sequencer;

    localparam logic [16:0] HALT = 17'h1C000;
    localparam logic [16:0] OPA  = 17'b00110010010001101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  imemAddr;
    logic [16:0] imemData;
    logic [16:0] instruction;
    logic        instrValid;
    logic [31:0] result;
    logic        zFlag;
    logic [31:0] lastResult;
    logic        zQ;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    logic [16:0] rom [32];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          validCount;
    int          doneCount;
    int          doneCyc;
    logic        errAtDone;
    logic [4:0]  pcAtDone;
    logic [4:0]  pcAtFive;

    jericalla_sequencer #(.PC_WIDTH(5)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .imem_addr_o   (imemAddr),
        .imem_data_i   (imemData),
        .instruction_o (instruction),
        .instr_valid_o (instrValid),
        .result_i      (result),
        .z_flag_i      (zFlag),
        .last_result_o (lastResult),
        .z_q_o         (zQ),
        .pc_o          (pc),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the address presented in FETCH is valid in EXEC.
    always @(posedge clk) imemData <= rom[imemAddr];

    // Datapath stand-in: result is zero only for the all-zero instruction.
    assign result = {instruction, instruction[14:0]};
    assign zFlag  = (result == 32'd0);

    function automatic logic [31:0] expResult(input logic [16:0] ins);
        return {ins, ins[14:0]};
    endfunction

    task automatic applyStimulus(input logic startVal);
        start = startVal;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 17'h0;
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_valid", instrValid, 0);
        checkOutput("rst_instr", instruction, 0);
        checkOutput("rst_addr", imemAddr, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_last", lastResult, 0);
        checkOutput("rst_zq", zQ, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;
        applyStimulus(0);

        $display("[TB] straight line");
        rom[0] = OPA; rom[1] = OPA; rom[2] = HALT;
        cyc = 0;
        applyStimulus(1);
        checkOutput("sl_c1_busy", busy, 1);
        checkOutput("sl_c1_addr", imemAddr, 0);
        checkOutput("sl_c1_valid", instrValid, 0);
        applyStimulus(0);
        checkOutput("sl_c2_valid", instrValid, 1);
        checkOutput("sl_c2_instr", instruction, OPA);
        applyStimulus(0);
        checkOutput("sl_c3_pc", pc, 1);
        checkOutput("sl_c3_last", lastResult, expResult(OPA));
        checkOutput("sl_c3_instr", instruction, 0);
        applyStimulus(0);
        checkOutput("sl_c4_valid", instrValid, 1);
        checkOutput("sl_c4_instr", instruction, OPA);
        applyStimulus(0);
        checkOutput("sl_c5_addr", imemAddr, 2);
        applyStimulus(0);
        checkOutput("sl_c6_valid", instrValid, 0);
        checkOutput("sl_c6_done", done, 0);
        applyStimulus(0);
        checkOutput("sl_c7_done", done, 1);
        checkOutput("sl_c7_busy", busy, 0);
        checkOutput("sl_c7_err", err, 0);
        checkOutput("sl_c7_last", lastResult, expResult(OPA));
        checkOutput("sl_c7_pc", pc, 2);
        applyStimulus(0);
        checkOutput("sl_c8_done", done, 0);

        $display("[TB] branch taken");
        rom[0] = 17'h0; rom[1] = 17'h18005; rom[2] = HALT; rom[5] = HALT;
        cyc = 0;
        applyStimulus(1);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("bt_c3_pc", pc, 1);
        checkOutput("bt_c3_zq", zQ, 1);
        applyStimulus(0);
        checkOutput("bt_c4_valid", instrValid, 0);
        applyStimulus(0);
        checkOutput("bt_c5_pc", pc, 5);
        checkOutput("bt_c5_addr", imemAddr, 5);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("bt_c7_done", done, 1);
        checkOutput("bt_c7_pc", pc, 5);
        applyStimulus(0);

        $display("[TB] stale flag from previous run");
        rom[0] = 17'h18005; rom[1] = HALT;
        cyc = 0;
        applyStimulus(1);
        checkOutput("sf_c1_zq", zQ, 0);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("sf_c3_pc", pc, 1);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("sf_c5_done", done, 1);
        applyStimulus(0);

        $display("[TB] branch not taken");
        rom[0] = 17'h00001; rom[1] = 17'h18005; rom[2] = HALT;
        cyc = 0;
        applyStimulus(1);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("bn_c3_pc", pc, 1);
        checkOutput("bn_c3_zq", zQ, 0);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("bn_c5_pc", pc, 2);
        checkOutput("bn_c5_addr", imemAddr, 2);
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("bn_c7_done", done, 1);
        checkOutput("bn_c7_zq", zQ, 0);
        checkOutput("bn_c7_last", lastResult, expResult(17'h00001));
        applyStimulus(0);

        $display("[TB] start while busy");
        rom[0] = OPA; rom[1] = 17'h00007; rom[2] = HALT;
        cyc = 0; doneCount = 0; doneCyc = 0; pcAtFive = '0;
        applyStimulus(1);
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (cyc == 5) pcAtFive = pc;
            applyStimulus(cyc == 3);
        end
        checkOutput("sb_done_count", doneCount, 1);
        checkOutput("sb_done_cyc", doneCyc, 7);
        checkOutput("sb_pc_c5", pcAtFive, 2);
        checkOutput("sb_busy_after", busy, 0);

        $display("[TB] run-off");
        for (int i = 0; i < 32; i++) rom[i] = {3'b010, 14'(i + 1)};
        cyc = 0; validCount = 0; doneCount = 0; doneCyc = 0; errAtDone = 1'b0; pcAtDone = '1;
        applyStimulus(1);
        for (int k = 0; k < 70; k++) begin
            if (instrValid) validCount++;
            if (done) begin
                doneCount++;
                doneCyc   = cyc;
                errAtDone = err;
                pcAtDone  = pc;
            end
            applyStimulus(0);
        end
        checkOutput("ro_valid_count", validCount, 32);
        checkOutput("ro_done_count", doneCount, 1);
        checkOutput("ro_done_cyc", doneCyc, 65);
        checkOutput("ro_err", errAtDone, 1);
        checkOutput("ro_pc", pcAtDone, 0);
        checkOutput("ro_last", lastResult, expResult({3'b010, 14'd32}));
        checkOutput("ro_err_sticky", err, 1);

        $display("[TB] reset mid-run");
        for (int i = 0; i < 4; i++) rom[i] = {3'b011, 14'(i * 3 + 7)};
        rom[4] = HALT;
        cyc = 0;
        applyStimulus(1);
        checkOutput("rm_c1_err", err, 0);
        for (int k = 0; k < 7; k++) applyStimulus(0);
        checkOutput("rm_c8_pc", pc, 3);
        checkOutput("rm_c8_valid", instrValid, 1);
        checkOutput("rm_c8_last", lastResult, expResult({3'b011, 14'd13}));
        rst = 1'b1;
        applyStimulus(0);
        rst = 1'b0;
        checkOutput("rm_busy", busy, 0);
        checkOutput("rm_done", done, 0);
        checkOutput("rm_valid", instrValid, 0);
        checkOutput("rm_instr", instruction, 0);
        checkOutput("rm_addr", imemAddr, 0);
        checkOutput("rm_pc", pc, 0);
        checkOutput("rm_last", lastResult, 0);
        checkOutput("rm_zq", zQ, 0);
        checkOutput("rm_err", err, 0);
        applyStimulus(0);
        checkOutput("rm_idle_busy", busy, 0);
        cyc = 0; doneCyc = 0;
        applyStimulus(1);
        checkOutput("rs_c1_busy", busy, 1);
        checkOutput("rs_c1_pc", pc, 0);
        checkOutput("rs_c1_addr", imemAddr, 0);
        for (int k = 0; k < 14; k++) begin
            if (done) doneCyc = cyc;
            applyStimulus(0);
        end
        checkOutput("rs_done_cyc", doneCyc, 11);
        checkOutput("rs_last", lastResult, expResult({3'b011, 14'd16}));
        checkOutput("rs_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
